spi_flash_read_ctrl: RTL and testbench

SPI_FLASH_READ_CTRL -- requirements
Module: spi_flash_read_ctrl

---
 rtl/spi_ctrl_pkg.sv | 23 ++
 rtl/spi_flash_read_ctrl.sv | 163 ++++++++++++++++
 tb/tb_spi_flash_read_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// spi_ctrl_pkg
// Shared constants and the controller state type for the SPI flash read
// controller.
//   FLASH_READ_CMD : standard serial-flash READ opcode
//   ADDR_BYTES     : address bytes sent after the opcode (24-bit address)
//   DUMMY_BYTE     : filler byte clocked out while data is shifted back in
//   ctrl_state_t   : read controller FSM states
// -----------------------------------------------------------------------------
package spi_ctrl_pkg;

  localparam logic [7:0] FLASH_READ_CMD = 8'h03;
  localparam int         ADDR_BYTES     = 3;
  localparam logic [7:0] DUMMY_BYTE     = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RDY,
    FINISH
  } ctrl_state_t;

endpackage

// File: rtl/spi_flash_read_ctrl.sv
// -----------------------------------------------------------------------------
// spi_flash_read_ctrl
// Drives a byte-oriented SPI master (single CS) to perform serial-flash READ
// transactions: opcode 0x03, three address bytes, then one dummy byte per data
// byte wanted, all in one CS-low window. Bytes received during the header are
// discarded; each later byte is handed out on o_Data with a one-cycle
// o_Data_Valid, followed one cycle after the last byte by o_Done.
//
// Ports
//   i_Clk, i_Rst_L            clock (rising edge), async active-low reset
//   i_Req, i_Addr, i_Len      read request, 24-bit address, data byte count
//   o_Busy                    transaction in progress
//   o_Data, o_Data_Valid      received data byte and its qualifier
//   o_Done, o_Err             end-of-read pulse, illegal-length pulse
//   o_TX_Count                bytes per CS window, to the SPI master
//   o_TX_Byte, o_TX_DV        byte and valid pulse to the SPI master
//   i_TX_Ready                SPI master ready for another byte
//   i_RX_DV, i_RX_Byte        byte received by the SPI master
// -----------------------------------------------------------------------------
module spi_flash_read_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int MAX_READ_LEN = 4,
  parameter int CW           = $clog2(MAX_READ_LEN + 4 + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Req,
  input  logic [23:0]   i_Addr,
  input  logic [CW-1:0] i_Len,
  output logic          o_Busy,
  output logic [7:0]    o_Data,
  output logic          o_Data_Valid,
  output logic          o_Done,
  output logic          o_Err,
  output logic [CW-1:0] o_TX_Count,
  output logic [7:0]    o_TX_Byte,
  output logic          o_TX_DV,
  input  logic          i_TX_Ready,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte
);

  // opcode plus address bytes; these are echoed back as junk on MISO
  localparam logic [CW-1:0] HDR_BYTES = CW'(ADDR_BYTES + 1);
  localparam logic [CW-1:0] MAX_LEN   = CW'(MAX_READ_LEN);

  ctrl_state_t   state, state_nxt;
  logic [23:0]   addr_r;
  logic [CW-1:0] tx_cnt;
  logic [CW-1:0] rx_cnt;
  logic          wait_first;
  logic [7:0]    tx_byte;
  logic          len_ok;
  logic          req_seen;
  logic          accept;
  logic          reject;
  logic          rx_active;
  logic          last_rx;

  // A request in the o_Done cycle is deliberately not seen, so a requester
  // that simply holds i_Req gets exactly one new transaction per done.
  assign len_ok    = (i_Len != '0) && (i_Len <= MAX_LEN);
  assign req_seen  = (state == IDLE) && i_Req && !o_Done;
  assign accept    = req_seen && len_ok;
  assign reject    = req_seen && !len_ok;
  assign rx_active = (state == ISSUE) || (state == WAIT_RDY);
  assign last_rx   = i_RX_DV && (rx_cnt == o_TX_Count - CW'(1));
  assign o_Busy    = (state != IDLE);

  always_comb begin
    tx_byte = DUMMY_BYTE;
    case (tx_cnt)
      CW'(0):  tx_byte = FLASH_READ_CMD;
      CW'(1):  tx_byte = addr_r[23:16];
      CW'(2):  tx_byte = addr_r[15:8];
      CW'(3):  tx_byte = addr_r[7:0];
      default: tx_byte = DUMMY_BYTE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= IDLE;
    else          state <= state_nxt;
  end

  // The SPI master only drops its ready one cycle after taking a byte, so the
  // first WAIT_RDY cycle must not trust i_TX_Ready (wait_first).
  always_comb begin
    state_nxt = state;
    o_TX_DV   = 1'b0;
    o_TX_Byte = 8'h00;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        o_TX_Byte = tx_byte;
        if (i_TX_Ready) begin
          o_TX_DV   = 1'b1;
          state_nxt = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (last_rx)
          state_nxt = FINISH;
        else if (!wait_first && i_TX_Ready && (tx_cnt != o_TX_Count))
          state_nxt = ISSUE;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // o_TX_Count doubles as the latched transaction length and stays put
  // until the next accepted request.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      addr_r       <= '0;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
      wait_first   <= 1'b0;
      o_TX_Count   <= '0;
      o_Data       <= '0;
      o_Data_Valid <= 1'b0;
      o_Done       <= 1'b0;
      o_Err        <= 1'b0;
    end else begin
      o_Data_Valid <= 1'b0;
      o_Done       <= 1'b0;
      o_Err        <= 1'b0;
      wait_first   <= o_TX_DV;

      if (accept) begin
        addr_r     <= i_Addr;
        o_TX_Count <= i_Len + HDR_BYTES;
        tx_cnt     <= '0;
        rx_cnt     <= '0;
      end

      if (reject) o_Err <= 1'b1;

      if (o_TX_DV) tx_cnt <= tx_cnt + CW'(1);

      if (rx_active && i_RX_DV) begin
        rx_cnt <= rx_cnt + CW'(1);
        if (rx_cnt >= HDR_BYTES) begin
          o_Data       <= i_RX_Byte;
          o_Data_Valid <= 1'b1;
        end
      end

      if (state == FINISH) begin
        o_Done <= 1'b1;
        tx_cnt <= '0;
        rx_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_read_ctrl
// Self-checking bench for spi_flash_read_ctrl. A byte-level model of the SPI
// master plus flash answers each transmitted byte; a reference model built
// from the flash READ protocol predicts MOSI bytes, returned data and pulses.
// -----------------------------------------------------------------------------
module tb_spi_flash_read_ctrl;

  localparam int MAX_READ_LEN = 4;
  localparam int CW           = $clog2(MAX_READ_LEN + 4 + 1);

  logic          i_Clk = 1'b0;
  logic          i_Rst_L = 1'b0;
  logic          i_Req = 1'b0;
  logic [23:0]   i_Addr = '0;
  logic [CW-1:0] i_Len = '0;
  logic          o_Busy;
  logic [7:0]    o_Data;
  logic          o_Data_Valid;
  logic          o_Done;
  logic          o_Err;
  logic [CW-1:0] o_TX_Count;
  logic [7:0]    o_TX_Byte;
  logic          o_TX_DV;
  logic          i_TX_Ready;
  logic          i_RX_DV;
  logic [7:0]    i_RX_Byte;

  spi_flash_read_ctrl #(.MAX_READ_LEN(MAX_READ_LEN), .CW(CW)) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Req(i_Req), .i_Addr(i_Addr),
    .i_Len(i_Len), .o_Busy(o_Busy), .o_Data(o_Data),
    .o_Data_Valid(o_Data_Valid), .o_Done(o_Done), .o_Err(o_Err),
    .o_TX_Count(o_TX_Count), .o_TX_Byte(o_TX_Byte), .o_TX_DV(o_TX_DV),
    .i_TX_Ready(i_TX_Ready), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte)
  );

  always #5 i_Clk = ~i_Clk;

  int compared = 0;
  int mismatched = 0;
  int cycleCnt = 0;

  // reference data for the current read and what was observed
  logic [7:0] dataQ[$];
  logic [7:0] expMosi[$];
  logic [7:0] mosiQ[$];
  logic [7:0] gotQ[$];
  int windowCount, doneCnt, errCnt, txDvTotal, dvNoReady, holdErr;
  int doneCycle, lastValidCycle;
  logic [7:0] lastData;

  // SPI master + flash model
  logic       stall = 1'b0;
  logic       mReady;
  logic       mRxDv;
  logic [7:0] mRxByte;
  int mPhase, mCnt, byteIdx, windowLen;

  assign i_TX_Ready = mReady && !stall;
  assign i_RX_DV    = mRxDv;
  assign i_RX_Byte  = mRxByte;

  always @(posedge i_Clk) cycleCnt <= cycleCnt + 1;

  function automatic logic [7:0] flashResp(int idx);
    if (idx < 4) return 8'hFF;
    if (idx - 4 < dataQ.size()) return dataQ[idx-4];
    return 8'hEE;
  endfunction

  // A byte is taken on TX_DV; ready drops one cycle later (as the real master
  // does), the byte shifts for a random time, then RX_DV and ready return.
  always @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mReady <= 1'b1; mRxDv <= 1'b0; mRxByte <= 8'h00;
      mPhase <= 0; mCnt <= 0; byteIdx <= 0; windowLen <= 0;
    end else begin
      mRxDv <= 1'b0;
      case (mPhase)
        0: if (o_TX_DV && i_TX_Ready) begin
             mosiQ.push_back(o_TX_Byte);
             if (byteIdx == 0) begin
               windowCount <= windowCount + 1;
               windowLen   <= int'(o_TX_Count);
             end
             mPhase <= 1;
           end
        1: begin mReady <= 1'b0; mCnt <= int'($urandom_range(2, 6)); mPhase <= 2; end
        2: if (mCnt > 1) mCnt <= mCnt - 1;
           else begin
             mRxDv <= 1'b1; mRxByte <= flashResp(byteIdx);
             byteIdx <= byteIdx + 1; mPhase <= 3;
           end
        default: begin
          mReady <= 1'b1; mPhase <= 0;
          if (byteIdx == windowLen) byteIdx <= 0;
        end
      endcase
    end
  end

  // output monitor, sampled away from the active edge
  always @(negedge i_Clk) begin
    if (!i_Rst_L) lastData = 8'h00;
    else begin
      if (o_TX_DV) begin
        txDvTotal++;
        if (!i_TX_Ready) dvNoReady++;
      end
      if (o_Data_Valid) begin
        gotQ.push_back(o_Data); lastValidCycle = cycleCnt; lastData = o_Data;
      end else if (o_Data !== lastData) holdErr++;
      if (o_Done) begin doneCnt++; doneCycle = cycleCnt; end
      if (o_Err) errCnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // builds the expected MOSI stream for a read and clears the observations
  task automatic prepare(input logic [23:0] addr, input int len);
    expMosi = {8'h03, addr[23:16], addr[15:8], addr[7:0]};
    for (int i = 0; i < len; i++) expMosi.push_back(8'h00);
    mosiQ = {}; gotQ = {};
    windowCount = 0; doneCnt = 0; dvNoReady = 0; holdErr = 0;
  endtask

  task automatic randomData(input int len);
    dataQ = {};
    for (int i = 0; i < len; i++) dataQ.push_back(8'($urandom));
  endtask

  task automatic applyStimulus(input logic [23:0] addr, input int len, input bit checkLat);
    prepare(addr, len);
    @(posedge i_Clk); #1;
    i_Req = 1'b1; i_Addr = addr; i_Len = CW'(len);
    @(posedge i_Clk); #1;
    i_Req = 1'b0;
    if (checkLat) begin
      @(negedge i_Clk);
      checkOutput("first_tx_dv", o_TX_DV, 1);
      checkOutput("busy_after_accept", o_Busy, 1);
      checkOutput("tx_count", o_TX_Count, len + 4);
    end
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (doneCnt == 0 && n < 3000) begin
      @(negedge i_Clk); #1; n++;
    end
    checkOutput({tag, "_done_seen"}, doneCnt != 0, 1);
  endtask

  task automatic checkResults(input string tag, input int len);
    checkOutput({tag, "_mosi_len"}, mosiQ.size(), len + 4);
    for (int i = 0; i < mosiQ.size() && i < expMosi.size(); i++)
      checkOutput($sformatf("%s_mosi%0d", tag, i), mosiQ[i], expMosi[i]);
    checkOutput({tag, "_data_cnt"}, gotQ.size(), len);
    for (int i = 0; i < gotQ.size() && i < dataQ.size(); i++)
      checkOutput($sformatf("%s_data%0d", tag, i), gotQ[i], dataQ[i]);
    checkOutput({tag, "_done_lag"}, doneCycle - lastValidCycle, 1);
    checkOutput({tag, "_done_once"}, doneCnt, 1);
    checkOutput({tag, "_windows"}, windowCount, 1);
    checkOutput({tag, "_dv_ready"}, dvNoReady, 0);
    checkOutput({tag, "_data_hold"}, holdErr, 0);
  endtask

  task automatic errorCase(input int len);
    int errBefore = errCnt;
    int dvBefore = txDvTotal;
    @(posedge i_Clk); #1;
    i_Req = 1'b1; i_Len = CW'(len); i_Addr = 24'($urandom);
    @(posedge i_Clk); #1;
    i_Req = 1'b0;
    @(negedge i_Clk);
    checkOutput($sformatf("err_pulse_len%0d", len), o_Err, 1);
    repeat (6) @(negedge i_Clk);
    checkOutput($sformatf("err_once_len%0d", len), errCnt - errBefore, 1);
    checkOutput($sformatf("err_no_dv_len%0d", len), txDvTotal - dvBefore, 0);
    checkOutput($sformatf("err_idle_len%0d", len), o_Busy, 0);
  endtask

  initial begin
    int len, dvBefore, n;
    logic [23:0] addr;
    windowCount = 0; doneCnt = 0; errCnt = 0; txDvTotal = 0;
    dvNoReady = 0; holdErr = 0; doneCycle = 0; lastValidCycle = 0;
    repeat (3) @(posedge i_Clk);
    #1 i_Rst_L = 1'b1;
    @(negedge i_Clk);
    checkOutput("reset_outputs",
      {o_Busy, o_Data, o_Data_Valid, o_Done, o_Err, o_TX_Count, o_TX_Byte, o_TX_DV}, 0);

    // single byte read
    dataQ = {8'h5A};
    applyStimulus(24'hADBEEF, 1, 1'b1);
    waitDone("rd1"); checkResults("rd1", 1);
    @(negedge i_Clk); checkOutput("rd1_busy_fall", o_Busy, 0);

    // maximum length read
    dataQ = {8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(24'h012345, 4, 1'b1);
    waitDone("rd4"); checkResults("rd4", 4);
    @(negedge i_Clk); checkOutput("rd4_busy_fall", o_Busy, 0);

    // illegal lengths
    errorCase(0);
    errorCase(5);

    // second request during address bytes is dropped; request held through
    // o_Done is taken on the following idle cycle
    randomData(3);
    applyStimulus(24'h00C0DE, 3, 1'b1);
    n = 0;
    while (mosiQ.size() < 2 && n < 500) begin @(negedge i_Clk); n++; end
    @(posedge i_Clk); #1; i_Req = 1'b1; i_Addr = 24'hFFFFFF; i_Len = CW'(1);
    @(posedge i_Clk); #1; i_Req = 1'b0;
    waitDone("busyreq"); checkResults("busyreq", 3);
    randomData(2);
    prepare(24'h00ABCD, 2);
    i_Req = 1'b1; i_Addr = 24'h00ABCD; i_Len = CW'(2);
    @(posedge i_Clk); #1; checkOutput("req_in_done_ignored", o_Busy, 0);
    @(posedge i_Clk); #1; checkOutput("held_req_accepted", o_Busy, 1);
    i_Req = 1'b0;
    waitDone("heldreq"); checkResults("heldreq", 2);
    repeat (20) @(negedge i_Clk);
    checkOutput("no_extra_window", windowCount, 1);

    // reset during the Addr[15:8] byte
    randomData(4);
    applyStimulus(24'h456789, 4, 1'b1);
    n = 0;
    while (mosiQ.size() < 3 && n < 500) begin @(negedge i_Clk); #1; n++; end
    i_Rst_L = 1'b0;
    #1 checkOutput("midreset_outputs",
      {o_Busy, o_Data, o_Data_Valid, o_Done, o_Err, o_TX_Count, o_TX_Byte, o_TX_DV}, 0);
    repeat (2) @(posedge i_Clk);
    #1 i_Rst_L = 1'b1;
    randomData(2);
    applyStimulus(24'h000010, 2, 1'b1);
    waitDone("postrst"); checkResults("postrst", 2);

    // ready held low before the first byte
    randomData(3);
    stall = 1'b1;
    dvBefore = txDvTotal;
    applyStimulus(24'h13579B, 3, 1'b0);
    repeat (20) @(negedge i_Clk);
    checkOutput("stall_no_dv", txDvTotal - dvBefore, 0);
    checkOutput("stall_busy", o_Busy, 1);
    stall = 1'b0;
    waitDone("stall"); checkResults("stall", 3);

    // randomized reads with occasional illegal requests
    for (int t = 0; t < 10; t++) begin
      len  = int'($urandom_range(1, MAX_READ_LEN));
      addr = 24'($urandom);
      randomData(len);
      applyStimulus(addr, len, 1'b1);
      waitDone($sformatf("rnd%0d", t));
      checkResults($sformatf("rnd%0d", t), len);
      @(negedge i_Clk); checkOutput($sformatf("rnd%0d_busy_fall", t), o_Busy, 0);
      if ($urandom_range(0, 2) == 0) errorCase(int'($urandom_range(5, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
